// File: rtl/sem_arbiter_if.sv
// sem_arbiter_if: request/release/grant handshake bundle between requesters and the semaphore arbiter
interface sem_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int TOKENS = 2,
  parameter int CW = $clog2(TOKENS + 1)
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] rel;
  logic [NUM_REQ-1:0] grant;
  logic [CW-1:0] avail;
  logic full;
  logic err;
  modport master (output req, rel, input grant, avail, full, err);
  modport slave (input req, rel, output grant, avail, full, err);
endinterface

// File: rtl/sem_arbiter.sv
// sem_arbiter: counting semaphore sharing TOKENS slots among NUM_REQ requesters with round-robin grants
module sem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TOKENS = 2,
  parameter int CW = $clog2(TOKENS + 1)
) (
  input logic clk,
  input logic reset,
  sem_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] grant_q, grant_d, wait_v, legal_rel, win_oh;
  logic [CW-1:0] avail_q, avail_d, rel_cnt;
  logic [PW-1:0] ptr_q, ptr_d, win;
  logic [PW:0] idx;
  logic found, do_grant;
  assign wait_v = bus.req & ~grant_q;
  assign legal_rel = bus.rel & grant_q;
  // scan waiters starting at ptr, wrapping; idx never exceeds 2*NUM_REQ-2
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = '0;
    rel_cnt = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(k);
      idx = idx >= (PW+1)'(NUM_REQ) ? idx - (PW+1)'(NUM_REQ) : idx;
      if (!found && wait_v[PW'(idx)]) begin
        found = 1'b1;
        win = PW'(idx);
      end
      rel_cnt = rel_cnt + CW'(legal_rel[k]);
    end
  end
  // grants only consume tokens free at the start of the cycle
  always_comb begin
    do_grant = found && avail_q != '0;
    win_oh = do_grant ? NUM_REQ'(1) << win : '0;
    grant_d = (grant_q & ~legal_rel) | win_oh;
    avail_d = avail_q + rel_cnt - CW'(do_grant);
    ptr_d = do_grant ? (win == PW'(NUM_REQ - 1) ? '0 : win + 1'b1) : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q <= '0;
      avail_q <= CW'(TOKENS);
      ptr_q <= '0;
      bus.full <= TOKENS == 0;
      bus.err <= 1'b0;
    end else begin
      grant_q <= grant_d;
      avail_q <= avail_d;
      ptr_q <= ptr_d;
      bus.full <= avail_d == '0;
      bus.err <= |(bus.rel & ~grant_q);
    end
  end
  assign bus.grant = grant_q;
  assign bus.avail = avail_q;
endmodule
